wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - the in-order pipeline writeback (rd, data and enable from the writeback stage);
  - the long-latency unit (divider / late load) returning results out of band.
- Pipeline writes have priority. Long-unit results are buffered in a small FIFO and drained on idle port cycles.
- Tracks pending long-unit destinations for hazard stalling. Forces a pipeline stall when buffered results starve.

Parameters:
- XLEN, 32, data width.
- FIFO_DEPTH, 2, long-result buffer entries (power of two, ≥2).
- STARVE_LIMIT, 4, consecutive lost-arbitration cycles before forced drain.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- pipe_we_i  in  1  pipeline writeback enable (already stall-gated upstream).
- pipe_rd_i  in  5  pipeline destination register.
- pipe_data_i  in  XLEN  pipeline writeback data.
- lu_issue_i  in  1  long-unit op issued this cycle.
- lu_issue_rd_i  in  5  destination of the issued long op.
- lu_valid_i  in  1  long-unit result valid.
- lu_rd_i  in  5  long-unit result destination.
- lu_data_i  in  XLEN  long-unit result data.
- lu_ready_o  out  1  arbiter accepts the long-unit result.
- rf_we_o  out  1  register-file write enable.
- rf_waddr_o  out  5  register-file write address.
- rf_wdata_o  out  XLEN  register-file write data.
- busy_mask_o  out  32  bit r set means a long-unit write to xr is pending.
- stall_req_o  out  1  request to freeze the pipeline (forced drain).
- fifo_cnt_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset, asynchronous on rst_ni low:
  - FIFO empty, fifo_cnt_o=0, busy_mask_o=0, starvation counter 0, FSM in NORMAL, stall_req_o=0.
  - rf_we_o=0, and lu_ready_o=1 once reset is released.
  - Reset during any operation discards buffered results and pending bits.
- Long-unit handshake:
  - Transfer happens when lu_valid_i && lu_ready_o.
  - lu_ready_o = (fifo_cnt < FIFO_DEPTH) && state==NORMAL. It is computed from registered state only, so a pop does not free a slot in the same cycle.
  - If lu_rd_i==0, the transfer is accepted and dropped (not pushed).
- FSM states: NORMAL and FORCE_DRAIN. stall_req_o = (state==FORCE_DRAIN), registered.
- Port mux in NORMAL (combinational outputs):
  - If pipe_we_i && pipe_rd_i!=0, the pipe wins.
  - Otherwise, if the FIFO is non-empty, pop the head and write it.
  - Otherwise rf_we_o=0.
  - Pipe writes to x0 produce rf_we_o=0 and count as an idle cycle for the FIFO.
- Port mux in FORCE_DRAIN: pop the head every cycle and ignore pipe_we_i (the pipeline is frozen and re-presents its write after the stall).
- Latency: an accepted result is written at the earliest on the next cycle. There is no same-cycle bypass.
- Starvation counter:
  - Increments when the FIFO is non-empty and the pipe wins.
  - Clears on any pop, or when the FIFO is empty.
- NORMAL→FORCE_DRAIN when the counter reaches STARVE_LIMIT at a clock edge. The counter clears on entry.
- FORCE_DRAIN→NORMAL on the edge where the pop empties the FIFO. stall_req_o falls in the following cycle.
- FIFO is simultaneous push/pop safe at any non-full occupancy. Pointers wrap modulo FIFO_DEPTH.
- busy_mask_o:
  - Bit r is set on the edge after lu_issue_i with lu_issue_rd_i=r≠0.
  - Bit r is cleared on the edge where a FIFO entry with rd=r is written to the register file.
  - If a set and a clear for the same r coincide, set wins.
  - Bit 0 is always 0.
- Protocol errors (simulation assertions only; RTL behaviour is undefined):
  - pipe write to a register whose busy bit is set;
  - lu_valid_i for a register whose busy bit is clear.

Test Plan:
- Idle port: lu_issue rd=5, then lu_valid rd=5 data=0x1234, pipe idle → busy_mask_o[5]=1 after issue; at the next cycle rf_we_o=1, waddr=5, wdata=0x1234; busy_mask_o[5]=0 one edge later.
- Priority: lu_valid rd=7 pushed, pipe writes rd=3 0xAA for 2 cycles → RF gets x3 twice, then x7 in the third cycle; fifo_cnt_o 1→1→0.
- Full backpressure: 2 results pushed while the pipe writes continuously → fifo_cnt_o=2, lu_ready_o=0, third result held until a slot frees.
- Starvation, STARVE_LIMIT=4: FIFO holds 2 entries, pipe writes every cycle → stall_req_o=1 after 4 lost cycles; next 2 cycles write FIFO entries; stall_req_o=0 the cycle after the FIFO empties.
- x0 handling: lu_issue rd=0, then lu_valid rd=0 → busy_mask_o stays 0, no RF write, fifo_cnt_o stays 0. A pipe write with rd=0 lets a queued entry drain that cycle.
- Reset mid-drain: rst_ni low during FORCE_DRAIN with fifo_cnt_o=1 → all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bus shared by the pipeline writeback and the long-latency unit.
// Signal names are seen from the arbiter: *_i are driven by the requesters, *_o by the arbiter.
interface wb_port_arbiter_if #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             pipe_we_i;
    logic [4:0]       pipe_rd_i;
    logic [XLEN-1:0]  pipe_data_i;
    logic             lu_issue_i;
    logic [4:0]       lu_issue_rd_i;
    logic             lu_valid_i;
    logic [4:0]       lu_rd_i;
    logic [XLEN-1:0]  lu_data_i;
    logic             lu_ready_o;
    logic             rf_we_o;
    logic [4:0]       rf_waddr_o;
    logic [XLEN-1:0]  rf_wdata_o;
    logic [31:0]      busy_mask_o;
    logic             stall_req_o;
    logic [CNT_W-1:0] fifo_cnt_o;

    modport master (
        output pipe_we_i, pipe_rd_i, pipe_data_i,
        output lu_issue_i, lu_issue_rd_i, lu_valid_i, lu_rd_i, lu_data_i,
        input  lu_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
        input  busy_mask_o, stall_req_o, fifo_cnt_o
    );

    modport slave (
        input  pipe_we_i, pipe_rd_i, pipe_data_i,
        input  lu_issue_i, lu_issue_rd_i, lu_valid_i, lu_rd_i, lu_data_i,
        output lu_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
        output busy_mask_o, stall_req_o, fifo_cnt_o
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writes win, long-unit results queue in a FIFO,
// drain on idle cycles and force a pipeline stall after STARVE_LIMIT consecutive losses.
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    wb_port_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        NORMAL      = 1'b0,
        FORCE_DRAIN = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [XLEN-1:0]  fifo_data [FIFO_DEPTH];
    logic [4:0]       fifo_rd   [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [STV_W-1:0] starve_q, starve_d;
    logic [31:0]      busy_q, busy_d;

    logic             fifo_empty, pipe_live;
    logic             push, pop, pipe_wins, lu_ready;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [XLEN-1:0]  rf_wdata;

    assign fifo_empty = (cnt_q == '0);
    assign pipe_live  = bus.pipe_we_i && (bus.pipe_rd_i != 5'd0);
    assign push       = bus.lu_valid_i && lu_ready && (bus.lu_rd_i != 5'd0);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= NORMAL;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Next-state logic, including the starvation counter that drives it
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d  = state_q;
        starve_d = starve_q;
        unique case (state_q)
            NORMAL: begin
                if (pop || fifo_empty) begin
                    starve_d = '0;
                end else if (pipe_wins) begin
                    starve_d = starve_q + STV_W'(1);
                end
                if (starve_d == STV_W'(STARVE_LIMIT)) begin
                    state_d  = FORCE_DRAIN;
                    starve_d = '0;
                end
            end
            FORCE_DRAIN: begin
                starve_d = '0;
                if (cnt_q <= CNT_W'(1)) state_d = NORMAL;
            end
        endcase
    end

    // Output logic: port mux and long-unit handshake
    always_comb begin
        pipe_wins = 1'b0;
        pop       = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = 5'd0;
        rf_wdata  = '0;
        // Gated by rst_ni so the port stays quiet while reset is held, regardless of inputs.
        lu_ready  = rst_ni && (cnt_q < CNT_W'(FIFO_DEPTH)) && (state_q == NORMAL);
        if (state_q == NORMAL && pipe_live) begin
            pipe_wins = 1'b1;
            rf_we     = rst_ni;
            rf_waddr  = bus.pipe_rd_i;
            rf_wdata  = bus.pipe_data_i;
        end else if (!fifo_empty) begin
            pop       = 1'b1;
            rf_we     = 1'b1;
            rf_waddr  = fifo_rd[rptr_q];
            rf_wdata  = fifo_data[rptr_q];
        end
    end

    // Pending-destination tracking; a new issue overrides a coincident retire
    always_comb begin
        busy_d = busy_q;
        if (pop) busy_d[fifo_rd[rptr_q]] = 1'b0;
        if (bus.lu_issue_i) busy_d[bus.lu_issue_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            busy_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)  rptr_q <= rptr_q + PTR_W'(1);
            cnt_q  <= cnt_q + CNT_W'(push) - CNT_W'(pop);
            busy_q <= busy_d;
        end
    end

    // NOTE: payload storage has no reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data[wptr_q] <= bus.lu_data_i;
            fifo_rd[wptr_q]   <= bus.lu_rd_i;
        end
    end

    assign bus.lu_ready_o  = lu_ready;
    assign bus.rf_we_o     = rf_we;
    assign bus.rf_waddr_o  = rf_waddr;
    assign bus.rf_wdata_o  = rf_wdata;
    assign bus.busy_mask_o = busy_q;
    assign bus.stall_req_o = (state_q == FORCE_DRAIN);
    assign bus.fifo_cnt_o  = cnt_q;

    // Requester protocol: no pipe write to a pending register, no result for an unissued one
    a_pipe_not_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == NORMAL && pipe_live) |-> !busy_q[bus.pipe_rd_i]);
    a_lu_was_issued: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.lu_valid_i && bus.lu_rd_i != 5'd0) |-> busy_q[bus.lu_rd_i]);
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scenarios plus a randomized run against a queue-based model of the write-port arbiter.
module tb_wb_port_arbiter;
    localparam int XLEN         = 32;
    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_LIMIT = 4;
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    wb_port_arbiter_if #(.XLEN(XLEN), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    wb_port_arbiter #(
        .XLEN(XLEN), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic pwe, input logic [4:0] prd, input logic [XLEN-1:0] pdata,
                         input logic iss, input logic [4:0] ird,
                         input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ldata);
        bus.pipe_we_i     = pwe;
        bus.pipe_rd_i     = prd;
        bus.pipe_data_i   = pdata;
        bus.lu_issue_i    = iss;
        bus.lu_issue_rd_i = ird;
        bus.lu_valid_i    = lv;
        bus.lu_rd_i       = lrd;
        bus.lu_data_i     = ldata;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b0, 5'd0, '0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        drive(1'b0, 5'd0, '0, 1'b1, rd, 1'b0, 5'd0, '0);
        tick();
    endtask

    task automatic test_reset();
        drive(1'b1, 5'd3, 32'hDEAD, 1'b0, 5'd0, 1'b0, 5'd0, '0);
        rst_ni = 1'b0;
        #12;
        n_cmp++; if (bus.rf_we_o !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %0b want 0", bus.rf_we_o); end
        n_cmp++; if (bus.fifo_cnt_o !== '0) begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", bus.fifo_cnt_o); end
        n_cmp++; if (bus.busy_mask_o !== 32'h0) begin n_bad++; $display("FAIL rst_busy: got %08h want 0", bus.busy_mask_o); end
        n_cmp++; if (bus.stall_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %0b want 0", bus.stall_req_o); end
        idle();
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        n_cmp++; if (bus.lu_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %0b want 1", bus.lu_ready_o); end
    endtask

    task automatic test_idle_port();
        issue(5'd5);
        n_cmp++; if (bus.busy_mask_o[5] !== 1'b1) begin n_bad++; $display("FAIL idle_busy_set: got %0b want 1", bus.busy_mask_o[5]); end
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b1, 5'd5, 32'h1234);
        #1;
        n_cmp++; if (bus.lu_ready_o !== 1'b1) begin n_bad++; $display("FAIL idle_ready: got %0b want 1", bus.lu_ready_o); end
        n_cmp++; if (bus.rf_we_o !== 1'b0) begin n_bad++; $display("FAIL idle_no_bypass: got %0b want 0", bus.rf_we_o); end
        tick();
        idle();
        #1;
        n_cmp++; if (bus.rf_we_o !== 1'b1) begin n_bad++; $display("FAIL idle_we: got %0b want 1", bus.rf_we_o); end
        n_cmp++; if (bus.rf_waddr_o !== 5'd5) begin n_bad++; $display("FAIL idle_waddr: got %0d want 5", bus.rf_waddr_o); end
        n_cmp++; if (bus.rf_wdata_o !== 32'h1234) begin n_bad++; $display("FAIL idle_wdata: got %08h want 00001234", bus.rf_wdata_o); end
        n_cmp++; if (bus.busy_mask_o[5] !== 1'b1) begin n_bad++; $display("FAIL idle_busy_hold: got %0b want 1", bus.busy_mask_o[5]); end
        tick();
        n_cmp++; if (bus.busy_mask_o !== 32'h0) begin n_bad++; $display("FAIL idle_busy_clr: got %08h want 0", bus.busy_mask_o); end
        n_cmp++; if (bus.rf_we_o !== 1'b0) begin n_bad++; $display("FAIL idle_we_after: got %0b want 0", bus.rf_we_o); end
    endtask

    task automatic test_priority();
        issue(5'd7);
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h77);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5'd3, 32'hAA, 1'b0, 5'd0, 1'b0, 5'd0, '0);
            #1;
            n_cmp++; if (bus.rf_waddr_o !== 5'd3 || bus.rf_wdata_o !== 32'hAA) begin n_bad++; $display("FAIL prio_pipe%0d: got x%0d=%08h want x3=000000aa", i, bus.rf_waddr_o, bus.rf_wdata_o); end
            n_cmp++; if (bus.fifo_cnt_o !== CNT_W'(1)) begin n_bad++; $display("FAIL prio_cnt%0d: got %0d want 1", i, bus.fifo_cnt_o); end
            tick();
        end
        idle();
        #1;
        n_cmp++; if (bus.rf_we_o !== 1'b1 || bus.rf_waddr_o !== 5'd7 || bus.rf_wdata_o !== 32'h77) begin n_bad++; $display("FAIL prio_drain: got we=%0b x%0d=%08h want we=1 x7=00000077", bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o); end
        tick();
        n_cmp++; if (bus.fifo_cnt_o !== '0) begin n_bad++; $display("FAIL prio_cnt_end: got %0d want 0", bus.fifo_cnt_o); end
    endtask

    task automatic test_backpressure();
        issue(5'd8);
        issue(5'd9);
        issue(5'd10);
        drive(1'b1, 5'd3, 32'h1, 1'b0, 5'd0, 1'b1, 5'd8, 32'h80);
        tick();
        drive(1'b1, 5'd3, 32'h2, 1'b0, 5'd0, 1'b1, 5'd9, 32'h90);
        tick();
        drive(1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 1'b1, 5'd10, 32'hA0);
        #1;
        n_cmp++; if (bus.fifo_cnt_o !== CNT_W'(2)) begin n_bad++; $display("FAIL bp_cnt_full: got %0d want 2", bus.fifo_cnt_o); end
        n_cmp++; if (bus.lu_ready_o !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full: got %0b want 0", bus.lu_ready_o); end
        tick();
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b1, 5'd10, 32'hA0);
        #1;
        n_cmp++; if (bus.lu_ready_o !== 1'b0) begin n_bad++; $display("FAIL bp_ready_pop: got %0b want 0", bus.lu_ready_o); end
        n_cmp++; if (bus.rf_waddr_o !== 5'd8 || bus.rf_wdata_o !== 32'h80) begin n_bad++; $display("FAIL bp_w8: got x%0d=%08h want x8=00000080", bus.rf_waddr_o, bus.rf_wdata_o); end
        tick();
        #1;
        n_cmp++; if (bus.lu_ready_o !== 1'b1) begin n_bad++; $display("FAIL bp_ready_free: got %0b want 1", bus.lu_ready_o); end
        n_cmp++; if (bus.rf_waddr_o !== 5'd9 || bus.rf_wdata_o !== 32'h90) begin n_bad++; $display("FAIL bp_w9: got x%0d=%08h want x9=00000090", bus.rf_waddr_o, bus.rf_wdata_o); end
        tick();
        idle();
        #1;
        n_cmp++; if (bus.fifo_cnt_o !== CNT_W'(1)) begin n_bad++; $display("FAIL bp_cnt_pushpop: got %0d want 1", bus.fifo_cnt_o); end
        n_cmp++; if (bus.rf_waddr_o !== 5'd10 || bus.rf_wdata_o !== 32'hA0) begin n_bad++; $display("FAIL bp_w10: got x%0d=%08h want x10=000000a0", bus.rf_waddr_o, bus.rf_wdata_o); end
        tick();
        n_cmp++; if (bus.fifo_cnt_o !== '0 || bus.busy_mask_o !== 32'h0) begin n_bad++; $display("FAIL bp_end: got cnt=%0d busy=%08h want cnt=0 busy=0", bus.fifo_cnt_o, bus.busy_mask_o); end
    endtask

    // Fills the FIFO under continuous pipe writes until the arbiter forces a drain
    task automatic fill_and_starve(input logic [4:0] ra, input logic [4:0] rb, input string tag);
        issue(ra);
        issue(rb);
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b1, ra, 32'h100 + 32'(ra));
        tick();
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b1, rb, 32'h100 + 32'(rb));
        tick();
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b0, 5'd0, '0);
        for (int i = 0; i < STARVE_LIMIT - 1; i++) begin
            #1;
            n_cmp++; if (bus.stall_req_o !== 1'b0) begin n_bad++; $display("FAIL %s_early_stall%0d: got %0b want 0", tag, i, bus.stall_req_o); end
            tick();
        end
    endtask

    task automatic test_starvation();
        fill_and_starve(5'd11, 5'd12, "starve");
        #1;
        n_cmp++; if (bus.stall_req_o !== 1'b1 || bus.lu_ready_o !== 1'b0) begin n_bad++; $display("FAIL starve_d1_ctl: got stall=%0b ready=%0b want 1 0", bus.stall_req_o, bus.lu_ready_o); end
        n_cmp++; if (bus.rf_waddr_o !== 5'd11 || bus.rf_wdata_o !== 32'h10B) begin n_bad++; $display("FAIL starve_d1_w: got x%0d=%08h want x11=0000010b", bus.rf_waddr_o, bus.rf_wdata_o); end
        tick();
        n_cmp++; if (bus.stall_req_o !== 1'b1 || bus.rf_waddr_o !== 5'd12) begin n_bad++; $display("FAIL starve_d2: got stall=%0b x%0d want stall=1 x12", bus.stall_req_o, bus.rf_waddr_o); end
        tick();
        n_cmp++; if (bus.stall_req_o !== 1'b0 || bus.fifo_cnt_o !== '0) begin n_bad++; $display("FAIL starve_exit: got stall=%0b cnt=%0d want 0 0", bus.stall_req_o, bus.fifo_cnt_o); end
        n_cmp++; if (bus.rf_waddr_o !== 5'd3) begin n_bad++; $display("FAIL starve_pipe_back: got x%0d want x3", bus.rf_waddr_o); end
        tick();
        idle();
    endtask

    task automatic test_x0();
        issue(5'd0);
        n_cmp++; if (bus.busy_mask_o !== 32'h0) begin n_bad++; $display("FAIL x0_busy: got %08h want 0", bus.busy_mask_o); end
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, 1'b1, 5'd0, 32'h5555);
        #1;
        n_cmp++; if (bus.lu_ready_o !== 1'b1) begin n_bad++; $display("FAIL x0_ready: got %0b want 1", bus.lu_ready_o); end
        tick();
        idle();
        #1;
        n_cmp++; if (bus.fifo_cnt_o !== '0 || bus.rf_we_o !== 1'b0) begin n_bad++; $display("FAIL x0_dropped: got cnt=%0d we=%0b want 0 0", bus.fifo_cnt_o, bus.rf_we_o); end
        issue(5'd13);
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b1, 5'd13, 32'hD13);
        tick();
        drive(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 1'b0, 5'd0, '0);
        #1;
        n_cmp++; if (bus.rf_we_o !== 1'b1 || bus.rf_waddr_o !== 5'd13 || bus.rf_wdata_o !== 32'hD13) begin n_bad++; $display("FAIL x0_pipe_idle: got we=%0b x%0d=%08h want we=1 x13=00000d13", bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o); end
        tick();
        idle();
    endtask

    task automatic test_reset_mid_drain();
        fill_and_starve(5'd14, 5'd15, "rstd");
        tick();
        n_cmp++; if (bus.stall_req_o !== 1'b1 || bus.fifo_cnt_o !== CNT_W'(1)) begin n_bad++; $display("FAIL rstd_pre: got stall=%0b cnt=%0d want 1 1", bus.stall_req_o, bus.fifo_cnt_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (bus.stall_req_o !== 1'b0 || bus.fifo_cnt_o !== '0) begin n_bad++; $display("FAIL rstd_async_ctl: got stall=%0b cnt=%0d want 0 0", bus.stall_req_o, bus.fifo_cnt_o); end
        n_cmp++; if (bus.busy_mask_o !== 32'h0 || bus.rf_we_o !== 1'b0) begin n_bad++; $display("FAIL rstd_async_out: got busy=%08h we=%0b want 0 0", bus.busy_mask_o, bus.rf_we_o); end
        idle();
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        n_cmp++; if (bus.lu_ready_o !== 1'b1 || bus.stall_req_o !== 1'b0) begin n_bad++; $display("FAIL rstd_release: got ready=%0b stall=%0b want 1 0", bus.lu_ready_o, bus.stall_req_o); end
    endtask

    task automatic test_random();
        entry_t          q[$];
        entry_t          outst[$];
        entry_t          e;
        logic [31:0]     busy;
        int              starve;
        bit              drain, hold, lost;
        logic            pwe, iss, lv, e_ready, e_we, e_pop;
        logic [4:0]      prd, ird, lrd, e_addr;
        logic [XLEN-1:0] pdata, ldata, e_data;

        idle();
        rst_ni = 1'b0;
        #7;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        busy = '0; starve = 0; drain = 1'b0; hold = 1'b0;

        for (int c = 0; c < 800; c++) begin
            pwe   = ($urandom_range(0, 99) < 65);
            prd   = 5'($urandom_range(0, 31));
            if (prd != 5'd0 && busy[prd]) prd = 5'd0;
            pdata = $urandom;
            ird   = 5'($urandom_range(0, 31));
            iss   = ($urandom_range(0, 99) < 35) && (outst.size() < 4) && (ird == 5'd0 || !busy[ird]);
            lv = 1'b0; lrd = 5'd0; ldata = '0;
            if (outst.size() > 0 && (hold || $urandom_range(0, 99) < 50)) begin
                lv = 1'b1; lrd = outst[0].rd; ldata = outst[0].data;
            end
            drive(pwe, prd, pdata, iss, ird, lv, lrd, ldata);
            #1;

            e_ready = (q.size() < FIFO_DEPTH) && !drain;
            e_pop = 1'b0; e_we = 1'b0; e_addr = 5'd0; e_data = '0;
            if (!drain && pwe && prd != 5'd0) begin
                e_we = 1'b1; e_addr = prd; e_data = pdata;
            end else if (q.size() > 0) begin
                e_pop = 1'b1; e_we = 1'b1; e_addr = q[0].rd; e_data = q[0].data;
            end

            n_cmp++; if (bus.rf_we_o !== e_we) begin n_bad++; $display("FAIL rnd_we c=%0d: got %0b want %0b", c, bus.rf_we_o, e_we); end
            if (e_we) begin
                n_cmp++; if (bus.rf_waddr_o !== e_addr || bus.rf_wdata_o !== e_data) begin n_bad++; $display("FAIL rnd_write c=%0d: got x%0d=%08h want x%0d=%08h", c, bus.rf_waddr_o, bus.rf_wdata_o, e_addr, e_data); end
            end
            n_cmp++; if (bus.lu_ready_o !== e_ready) begin n_bad++; $display("FAIL rnd_ready c=%0d: got %0b want %0b", c, bus.lu_ready_o, e_ready); end
            n_cmp++; if (bus.stall_req_o !== drain) begin n_bad++; $display("FAIL rnd_stall c=%0d: got %0b want %0b", c, bus.stall_req_o, drain); end
            n_cmp++; if (bus.fifo_cnt_o !== CNT_W'(q.size())) begin n_bad++; $display("FAIL rnd_cnt c=%0d: got %0d want %0d", c, bus.fifo_cnt_o, q.size()); end
            n_cmp++; if (bus.busy_mask_o !== busy) begin n_bad++; $display("FAIL rnd_busy c=%0d: got %08h want %08h", c, bus.busy_mask_o, busy); end

            tick();

            lost = !drain && (q.size() > 0) && e_we && !e_pop;
            if (e_pop) begin
                busy[q[0].rd] = 1'b0;
                void'(q.pop_front());
            end
            if (lv && e_ready) begin
                if (lrd != 5'd0) begin
                    e.rd = lrd; e.data = ldata;
                    q.push_back(e);
                end
                void'(outst.pop_front());
                hold = 1'b0;
            end else begin
                hold = lv;
            end
            if (iss) begin
                if (ird != 5'd0) busy[ird] = 1'b1;
                e.rd = ird; e.data = $urandom;
                outst.push_back(e);
            end
            if (drain) begin
                starve = 0;
                if (q.size() == 0) drain = 1'b0;
            end else begin
                starve = lost ? starve + 1 : 0;
                if (starve == STARVE_LIMIT) begin
                    drain  = 1'b1;
                    starve = 0;
                end
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_idle_port();
        test_priority();
        test_backpressure();
        test_starvation();
        test_x0();
        test_reset_mid_drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
